// File: rtl/game_scheduler.sv
// game_scheduler: per-frame sequencer for the game datapath.
// Generates the frame tick and, once per frame, runs a physics update followed by an
// optional scroll step, each through a req/ack handshake with a timeout.
// Optional feature: define SCHED_SCORE_EN to add a saturating 16-bit score output.
module game_scheduler #(
  parameter int unsigned CLK         = 50000000,
  parameter int unsigned FPS         = 50,
  parameter int unsigned SCROLL_LINE = 300,
  parameter int unsigned FLOOR_Y     = 767,
  parameter int unsigned SCROLL_STEP = 4,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [8:0] delta_x,
  input  logic [9:0]        doodle_y,
  output logic              phys_req,
  input  logic              phys_ack,
  output logic              scroll_req,
  output logic [9:0]        scroll_amount,
  input  logic              scroll_ack,
  output logic [1:0]        move_counter,
  output logic              frame_tick,
  output logic [2:0]        run_state,
  output logic              game_over,
  output logic              fault,
  output logic [7:0]        overrun
`ifdef SCHED_SCORE_EN
  ,
  output logic [15:0]       score
`endif
);

  localparam logic [31:0] TickMax    = 32'(CLK / FPS - 1);
  localparam logic [31:0] WaitMax    = 32'(TIMEOUT - 1);
  localparam logic [9:0]  ScrollLine = 10'(SCROLL_LINE);
  localparam logic [9:0]  FloorY     = 10'(FLOOR_Y);
  localparam logic [9:0]  ScrollStep = 10'(SCROLL_STEP);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWait   = 3'd1,
    StPhys   = 3'd2,
    StScroll = 3'd3,
    StOver   = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] tick_q;
  logic [31:0] wait_q;
  logic        zero_seen_q;
  logic        phys_req_q;
  logic        scroll_req_q;
  logic [9:0]  scroll_amount_q;
  logic [1:0]  move_counter_q;
  logic        game_over_q;
  logic        fault_q;
  logic [7:0]  overrun_q;

  logic [9:0]  scroll_gap;
  logic [9:0]  scroll_next;
  logic        wait_expired;

  // Gap is only consumed when doodle_y < SCROLL_LINE, so it never underflows in use.
  assign scroll_gap   = ScrollLine - doodle_y;
  assign scroll_next  = (scroll_gap < ScrollStep) ? scroll_gap : ScrollStep;
  assign wait_expired = (wait_q == WaitMax);
  assign frame_tick   = (tick_q == TickMax);

`ifdef SCHED_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score_q} + {7'b0, scroll_amount_q};
  assign score     = score_q;
`endif

  // Free-running frame period counter, independent of game state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= '0;
    end else if (frame_tick) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 32'd1;
    end
  end

  // Game FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= StIdle;
      wait_q          <= '0;
      zero_seen_q     <= 1'b0;
      phys_req_q      <= 1'b0;
      scroll_req_q    <= 1'b0;
      scroll_amount_q <= '0;
      move_counter_q  <= '0;
      game_over_q     <= 1'b0;
      fault_q         <= 1'b0;
      overrun_q       <= '0;
`ifdef SCHED_SCORE_EN
      score_q         <= '0;
`endif
    end else begin
      // A tick landing mid-handshake is dropped, only counted.
      if (frame_tick && (state_q == StPhys || state_q == StScroll) && overrun_q != 8'hFF) begin
        overrun_q <= overrun_q + 8'd1;
      end
      case (state_q)
        StIdle: begin
          if (delta_x != '0) state_q <= StWait;
        end
        StWait: begin
          if (frame_tick) begin
            phys_req_q <= 1'b1;
            wait_q     <= '0;
            state_q    <= StPhys;
          end
        end
        StPhys: begin
          if (phys_ack) begin
            phys_req_q <= 1'b0;
            if (doodle_y >= FloorY) begin
              game_over_q <= 1'b1;
              zero_seen_q <= 1'b0;
              state_q     <= StOver;
            end else if (doodle_y < ScrollLine) begin
              scroll_amount_q <= scroll_next;
              scroll_req_q    <= 1'b1;
              wait_q          <= '0;
              state_q         <= StScroll;
            end else begin
              state_q <= StWait;
            end
          end else if (wait_expired) begin
            phys_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= StWait;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        StScroll: begin
          if (scroll_ack) begin
            scroll_req_q    <= 1'b0;
            scroll_amount_q <= '0;
            move_counter_q  <= move_counter_q + 2'd1;
`ifdef SCHED_SCORE_EN
            score_q         <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
            state_q         <= StWait;
          end else if (wait_expired) begin
            scroll_req_q    <= 1'b0;
            scroll_amount_q <= '0;
            fault_q         <= 1'b1;
            state_q         <= StWait;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        StOver: begin
          // Restart needs a release (delta_x == 0) followed by fresh activity.
          if (delta_x == '0) begin
            zero_seen_q <= 1'b1;
          end else if (zero_seen_q) begin
            game_over_q    <= 1'b0;
            move_counter_q <= '0;
            fault_q        <= 1'b0;
`ifdef SCHED_SCORE_EN
            score_q        <= '0;
`endif
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign phys_req      = phys_req_q;
  assign scroll_req    = scroll_req_q;
  assign scroll_amount = scroll_amount_q;
  assign move_counter  = move_counter_q;
  assign run_state     = state_q;
  assign game_over     = game_over_q;
  assign fault         = fault_q;
  assign overrun       = overrun_q;

endmodule
